// File: rtl/gv_pkg.sv
// Shared game-mode codes, timing limits and beat scheduler states.
// Used by state_fsm, main_game and beat_scheduler.
package gv_pkg;

  localparam logic [2:0] MODE_IDLE   = 3'd0;
  localparam logic [2:0] MODE_SELECT = 3'd1;
  localparam logic [2:0] MODE_PLAY   = 3'd2;
  localparam logic [2:0] MODE_RESULT = 3'd3;
  localparam logic [2:0] MODE_EDIT   = 3'd4;

  localparam int MIN_PERIOD = 2;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEAD,
    S_PLAY,
    S_DRAIN,
    S_DONE
  } sched_state_t;

endpackage

// File: rtl/beat_scheduler_if.sv
// Control and note bus between state_fsm/diff_speed and the beat scheduler.
// master drives mode/period/patterns/hold; slave returns beat and note info.
interface beat_scheduler_if #(
  parameter int NUM_NOTES = 32,
  parameter int PERIOD_W  = 23
);

  localparam int IW = $clog2(NUM_NOTES);

  logic [2:0]           mode;
  logic [PERIOD_W-1:0]  period;
  logic [NUM_NOTES-1:0] notes1;
  logic [NUM_NOTES-1:0] notes2;
  logic                 hold;

  logic                 beat_tick;
  logic                 note_valid;
  logic [1:0]           lane_notes;
  logic [IW-1:0]        note_idx;
  logic [2:0]           countdown;
  logic                 busy;
  logic                 finish;

  modport master (
    output mode, period, notes1, notes2, hold,
    input  beat_tick, note_valid, lane_notes,
    input  note_idx, countdown, busy, finish
  );

  modport slave (
    input  mode, period, notes1, notes2, hold,
    output beat_tick, note_valid, lane_notes,
    output note_idx, countdown, busy, finish
  );

endinterface

// File: rtl/beat_scheduler_timer.sv
// Beat period down-counter: load on round entry, freeze on hold,
// combinational tick when the count expires, reloading on that tick.
module beat_timer #(
  parameter int W = 23
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic         en,
  input  logic         hold,
  input  logic [W-1:0] reload_val,
  output logic         tick
);

  logic [W-1:0] cnt_q;

  assign tick = en && !hold && (cnt_q == '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else if (load || tick) begin
      cnt_q <= reload_val;
    end else if (en && !hold) begin
      cnt_q <= cnt_q - W'(1);
    end
  end

endmodule

// File: rtl/beat_scheduler.sv
// Round sequencer: lead-in countdown, one note pair per beat, drain, finish.
// BEAT_SCHED_SPEEDUP_EN shortens the beat period after every 8th note.
module beat_scheduler
  import gv_pkg::*;
#(
  parameter int NUM_NOTES   = 32,
  parameter int PERIOD_W    = 23,
  parameter int LEAD_BEATS  = 4,
  parameter int DRAIN_BEATS = 8
) (
  input  logic      clk,
  input  logic      reset,
  beat_scheduler_if.slave bus
);

  localparam int IW = $clog2(NUM_NOTES);
  localparam int BMAX =
    (LEAD_BEATS > DRAIN_BEATS) ? LEAD_BEATS : DRAIN_BEATS;
  localparam int BW = $clog2(BMAX + 1);

  sched_state_t         state_q, state_d;
  logic [2:0]           prev_mode_q;
  logic [PERIOD_W-1:0]  p_q, p_d, p_in, reload_val;
  logic [NUM_NOTES-1:0] snap1_q, snap1_d;
  logic [NUM_NOTES-1:0] snap2_q, snap2_d;
  logic [BW-1:0]        bc_q, bc_d;
  logic [IW-1:0]        idx_q, idx_d, pos;
  logic [IW-1:0]        nidx_d;
  logic [1:0]           lane_d;
  logic                 tick_d, nv_d, fin_d;
  logic                 play, entry, run, tick;

`ifdef BEAT_SCHED_SPEEDUP_EN
  logic [PERIOD_W-1:0]  p_fast;
  assign p_fast = p_q - (p_q >> 3);
`endif

  assign play  = bus.mode == MODE_PLAY;
  assign entry = (state_q == S_IDLE) && play &&
                 (prev_mode_q != MODE_PLAY);
  assign run   = play && (state_q inside {S_LEAD, S_PLAY, S_DRAIN});
  assign p_in  = (bus.period < PERIOD_W'(MIN_PERIOD)) ?
                 PERIOD_W'(MIN_PERIOD) : bus.period;
  assign reload_val = entry ? p_in - PERIOD_W'(1) : p_q - PERIOD_W'(1);
  assign pos   = IW'(NUM_NOTES - 1) - idx_q;

  beat_timer #(.W(PERIOD_W)) u_timer (
    .clk        (clk),
    .reset      (reset),
    .load       (entry),
    .en         (run),
    .hold       (bus.hold),
    .reload_val (reload_val),
    .tick       (tick)
  );

  always_comb begin
    state_d = state_q;
    p_d     = p_q;
    snap1_d = snap1_q;
    snap2_d = snap2_q;
    bc_d    = bc_q;
    idx_d   = idx_q;
    nidx_d  = bus.note_idx;
    lane_d  = 2'b00;
    tick_d  = 1'b0;
    nv_d    = 1'b0;
    fin_d   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (entry) begin
          state_d = S_LEAD;
          p_d     = p_in;
          snap1_d = bus.notes1;
          snap2_d = bus.notes2;
          bc_d    = BW'(LEAD_BEATS);
          idx_d   = '0;
          nidx_d  = '0;
        end
      end
      S_LEAD, S_PLAY, S_DRAIN: begin
        if (!play) begin
          state_d = S_IDLE;
          nidx_d  = '0;
        end else if (tick) begin
          tick_d = 1'b1;
          if (state_q == S_LEAD) begin
            bc_d = bc_q - BW'(1);
            if (bc_q == BW'(1)) begin
              state_d = S_PLAY;
              idx_d   = '0;
            end
          end else if (state_q == S_PLAY) begin
            nv_d   = 1'b1;
            lane_d = {snap2_q[pos], snap1_q[pos]};
            nidx_d = idx_q;
            idx_d  = idx_q + IW'(1);
`ifdef BEAT_SCHED_SPEEDUP_EN
            // new period takes effect at the reload after this one
            if (idx_q[2:0] == 3'b111) begin
              p_d = (p_fast < PERIOD_W'(MIN_PERIOD)) ?
                    PERIOD_W'(MIN_PERIOD) : p_fast;
            end
`endif
            if (idx_q == IW'(NUM_NOTES - 1)) begin
              state_d = S_DRAIN;
              bc_d    = BW'(DRAIN_BEATS);
            end
          end else begin
            bc_d = bc_q - BW'(1);
            if (bc_q == BW'(1)) begin
              state_d = S_DONE;
              fin_d   = 1'b1;
            end
          end
        end
      end
      S_DONE: begin
        if (!play) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    prev_mode_q <= bus.mode;
    if (reset) begin
      state_q        <= S_IDLE;
      p_q            <= '0;
      snap1_q        <= '0;
      snap2_q        <= '0;
      bc_q           <= '0;
      idx_q          <= '0;
      bus.beat_tick  <= 1'b0;
      bus.note_valid <= 1'b0;
      bus.lane_notes <= 2'b00;
      bus.note_idx   <= '0;
      bus.countdown  <= 3'd0;
      bus.busy       <= 1'b0;
      bus.finish     <= 1'b0;
    end else begin
      state_q        <= state_d;
      p_q            <= p_d;
      snap1_q        <= snap1_d;
      snap2_q        <= snap2_d;
      bc_q           <= bc_d;
      idx_q          <= idx_d;
      bus.beat_tick  <= tick_d;
      bus.note_valid <= nv_d;
      bus.lane_notes <= lane_d;
      bus.note_idx   <= nidx_d;
      bus.countdown  <= (state_d == S_LEAD) ? 3'(bc_d) : 3'd0;
      bus.busy       <= state_d inside {S_LEAD, S_PLAY, S_DRAIN};
      bus.finish     <= fin_d;
    end
  end

endmodule

// File: doc/beat_scheduler.md
Name: beat_scheduler

Overview:
- Sequences the two-lane note datapath during a play round.
- Generates the beat tick at the selected difficulty period and runs a lead-in countdown.
- Issues one note pair per beat from the 32-bit lane patterns, then drains the display and pulses finish to state_fsm.
- Sits between state_fsm/diff_speed and main_game; replaces finish_counter and supplies its beat_clk.

Parameters:
NUM_NOTES, 32, notes per lane pattern; note_idx width is $clog2(NUM_NOTES)
PERIOD_W, 23, width of the beat period in clk cycles
LEAD_BEATS, 4, countdown beats before the first note
DRAIN_BEATS, 8, beats after the last note so it scrolls off the 8 digits

Ports:
clk  in  1  system clock (hwclk at top)
reset  in  1  synchronous, active-high reset
mode  in  3  game mode from state_fsm
period  in  PERIOD_W  beat period from diff_speed, in clk cycles
notes1  in  NUM_NOTES  lane-1 pattern, MSB first
notes2  in  NUM_NOTES  lane-2 pattern, MSB first
hold  in  1  pause; freezes the beat counter
beat_tick  out  1  one-cycle pulse per beat
note_valid  out  1  one-cycle pulse carrying a note pair
lane_notes  out  2  {notes2 bit, notes1 bit}; valid with note_valid
note_idx  out  $clog2(NUM_NOTES)  index of the last issued note
countdown  out  3  remaining lead beats; 0 outside LEAD
busy  out  1  high in LEAD, PLAY and DRAIN
finish  out  1  one-cycle pulse at round end

Behaviour:
- Clock and reset
  - One clock. Reset is synchronous and active-high.
  - Reset forces IDLE and clears every output to 0.
  - Reset mid-round behaves identically; no finish is produced.
- Outputs: all registered.
- States: IDLE, LEAD, PLAY, DRAIN, DONE.
- Start
  - In IDLE, the cycle in which mode first equals MODE_PLAY (edge, registered previous mode) is the entry cycle.
  - Entry latches P = max(period, MIN_PERIOD) and snapshots notes1/notes2, so song-editor changes mid-round are ignored.
  - Entry loads countdown = LEAD_BEATS and goes to LEAD.
- Beat timing
  - Down-counter reloads to P-1 on entry and on each tick.
  - beat_tick rises exactly P cycles after the entry cycle, then every P cycles.
  - While hold=1 the counter freezes and no ticks occur; release resumes from the frozen value.
- LEAD: each tick decrements countdown. The tick that reaches 0 moves to PLAY with index 0; no note is issued on that tick.
- PLAY
  - Each tick asserts note_valid with lane_notes = {snap2[NUM_NOTES-1-i], snap1[NUM_NOTES-1-i]} and note_idx = i, then i++.
  - After issuing i = NUM_NOTES-1, go to DRAIN with drain count = DRAIN_BEATS.
- DRAIN: each tick decrements. The tick reaching 0 asserts finish together with that beat_tick and moves to DONE.
- DONE: no ticks. Wait for mode != MODE_PLAY, then go to IDLE. Re-entry requires a new edge.
- Abort: mode != MODE_PLAY while in LEAD, PLAY or DRAIN returns to IDLE next cycle, clears outputs, no finish.
- Priority: reset > abort > hold > tick.
- period = 0 or 1 is clamped to MIN_PERIOD = 2.
- A period change mid-round is ignored until the next entry.
- busy = state in {LEAD, PLAY, DRAIN}.

Optional Feature:
- Macro: BEAT_SCHED_SPEEDUP_EN.
- Defined: after every 8th issued note, P <= max(P - (P>>3), MIN_PERIOD). The new P applies from the next reload.
- Undefined: P stays constant for the round.

Decomposition:
- Package gv_pkg holds:
  - MODE_IDLE=0, MODE_SELECT=1, MODE_PLAY=2, MODE_RESULT=3, MODE_EDIT=4
  - MIN_PERIOD=2
  - sched_state_t enum
- Shared with state_fsm and main_game.
- One sub-module, beat_timer: period down-counter with load, hold and a tick output.

Test Plan:
1. period=4, notes1=32'hAAAAAAAA, notes2=32'hCCCCCCCC, mode -> PLAY at cycle 0:
   - beat_tick at cycles 4, 8, 12, 16, 20.
   - countdown 4 -> 3 -> 2 -> 1 -> 0.
   - first note_valid at cycle 20 with lane_notes=2'b11, then 2'b10 at 24, 2'b01 at 28.
2. Same setup, run to end:
   - last note (idx 31) at cycle 144.
   - finish pulses once at cycle 176; busy falls; no further ticks.
3. hold=1 for 10 cycles starting at cycle 6: ticks at 4, 18, 22; no note lost or duplicated.
4. mode -> MODE_RESULT at cycle 50 mid-PLAY: IDLE by cycle 51, all outputs 0, finish never asserted.
5. period=0: ticks every 2 cycles. Reset asserted at cycle 30: outputs 0 at cycle 31. Re-entry requires a fresh mode edge.
6. BEAT_SCHED_SPEEDUP_EN, period=64: P becomes 56 after note 8 and 49 after note 16; tick spacing is checked accordingly.
